// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared constants for the VGA sprite engine: default 640x480@60 timing,
// the derived line/frame totals, counter width and default colours.
// No ports (package).
// ---------------------------------------------------------------------------
package vga_pkg;

    // Default horizontal timing, in pixels
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

    // Default vertical timing, in lines
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // h/v counters are 11 bits so that a signed 11-bit difference against a
    // 10-bit ball centre never overflows inside the active area.
    localparam int CNT_W = 11;

    // Default colours, {R[3:0], G[3:0], B[3:0]}
    localparam logic [11:0] DEF_BG_RGB    = 12'h000;
    localparam logic [11:0] DEF_BALL_RGB  = 12'hF80;
    localparam logic [11:0] DEF_HOOP_RGB  = 12'hF00;
    localparam logic [11:0] BLANK_RGB     = 12'h000;

endpackage

// File: rtl/vga_timing.sv
// ---------------------------------------------------------------------------
// vga_timing
// Pixel-clock divider, horizontal/vertical raster counters and sync decode.
//
// Ports
//   clk          : system clock, rising edge
//   reset        : synchronous, active-high
//   pix_en       : one-clock strobe, once every CLK_DIV clocks
//   h, v         : current raster position (pixel column, line)
//   active       : (h, v) lies inside the visible area
//   vblank_start : pix_en on the last pixel of line V_ACTIVE-1, i.e. the
//                  strobe on which v moves into vertical blank
//   hsync, vsync : decoded sync levels for the current (h, v), unregistered
// ---------------------------------------------------------------------------
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int SYNC_POL = 0,
    parameter int CLK_DIV  = 4
) (
    input  logic             clk,
    input  logic             reset,
    output logic             pix_en,
    output logic [CNT_W-1:0] h,
    output logic [CNT_W-1:0] v,
    output logic             active,
    output logic             vblank_start,
    output logic             hsync,
    output logic             vsync
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // A one-bit divider that never leaves 0 covers CLK_DIV == 1.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT      = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT      = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_LAST = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic SYNC_LVL = (SYNC_POL != 0);

    logic [DIV_W-1:0] div;

    assign pix_en = (div == DIV_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            div <= '0;
        end else if (pix_en) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h <= '0;
            v <= '0;
        end else if (pix_en) begin
            if (h == H_LAST) begin
                h <= '0;
                if (v == V_LAST) begin
                    v <= '0;
                end else begin
                    v <= v + 1'b1;
                end
            end else begin
                h <= h + 1'b1;
            end
        end
    end

    assign active       = (h < H_ACT) && (v < V_ACT);
    assign vblank_start = pix_en && (h == H_LAST) && (v == V_ACT_LAST);
    assign hsync        = ((h >= HS_START) && (h < HS_END)) ? SYNC_LVL : ~SYNC_LVL;
    assign vsync        = ((v >= VS_START) && (v < VS_END)) ? SYNC_LVL : ~SYNC_LVL;

endmodule

// File: rtl/vga_sprite_engine.sv
// ---------------------------------------------------------------------------
// vga_sprite_engine
// VGA raster generator that draws a round ball over a fixed hoop rectangle.
// The ball centre is latched once per frame, at the start of vertical blank,
// so a frame is always drawn from a single consistent position.
//
// Ports
//   CLK100MHZ  : system clock, rising edge
//   reset      : synchronous, active-high
//   ball_x     : ball centre column (may be off-screen)
//   ball_y     : ball centre row (may be off-screen)
//   rgb        : registered pixel colour {R,G,B} 4 bits each
//   VGA_HS     : registered horizontal sync, aligned with rgb
//   VGA_VS     : registered vertical sync, aligned with rgb
//   frame_tick : one-clock pulse as the raster enters vertical blank
// ---------------------------------------------------------------------------
module vga_sprite_engine
    import vga_pkg::*;
#(
    parameter int          H_ACTIVE = DEF_H_ACTIVE,
    parameter int          H_FP     = DEF_H_FP,
    parameter int          H_SYNC   = DEF_H_SYNC,
    parameter int          H_BP     = DEF_H_BP,
    parameter int          V_ACTIVE = DEF_V_ACTIVE,
    parameter int          V_FP     = DEF_V_FP,
    parameter int          V_SYNC   = DEF_V_SYNC,
    parameter int          V_BP     = DEF_V_BP,
    parameter int          SYNC_POL = 0,
    parameter int          CLK_DIV  = 4,
    parameter int          BALL_R   = 8,
    parameter int          HOOP_X0  = 560,
    parameter int          HOOP_X1  = 600,
    parameter int          HOOP_Y0  = 120,
    parameter int          HOOP_Y1  = 126,
    parameter logic [11:0] BG_RGB   = DEF_BG_RGB,
    parameter logic [11:0] BALL_RGB = DEF_BALL_RGB,
    parameter logic [11:0] HOOP_RGB = DEF_HOOP_RGB
) (
    input  logic        CLK100MHZ,
    input  logic        reset,
    input  logic [9:0]  ball_x,
    input  logic [9:0]  ball_y,
    output logic [11:0] rgb,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        frame_tick
);

    localparam logic             SYNC_LVL = (SYNC_POL != 0);
    localparam logic [9:0]       CENTRE_X = 10'(H_ACTIVE / 2);
    localparam logic [9:0]       CENTRE_Y = 10'(V_ACTIVE / 2);
    localparam logic [21:0]      RADIUS_SQ = 22'(BALL_R * BALL_R);
    localparam logic [CNT_W-1:0] HX0 = CNT_W'(HOOP_X0);
    localparam logic [CNT_W-1:0] HX1 = CNT_W'(HOOP_X1);
    localparam logic [CNT_W-1:0] HY0 = CNT_W'(HOOP_Y0);
    localparam logic [CNT_W-1:0] HY1 = CNT_W'(HOOP_Y1);

    logic             pix_en;
    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;
    logic             active;
    logic             vblank_start;
    logic             hsync;
    logic             vsync;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .SYNC_POL (SYNC_POL),
        .CLK_DIV  (CLK_DIV)
    ) u_timing (
        .clk          (CLK100MHZ),
        .reset        (reset),
        .pix_en       (pix_en),
        .h            (h),
        .v            (v),
        .active       (active),
        .vblank_start (vblank_start),
        .hsync        (hsync),
        .vsync        (vsync)
    );

    // Shadow copy of the ball centre, refreshed only when entering vblank.
    logic [9:0] shadow_x;
    logic [9:0] shadow_y;

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            shadow_x <= CENTRE_X;
            shadow_y <= CENTRE_Y;
        end else if (vblank_start) begin
            shadow_x <= ball_x;
            shadow_y <= ball_y;
        end
    end

    // Signed distance from the latched centre. Only the active area uses the
    // result, where h and v are below 1024, so 11 bits hold every difference.
    logic signed [10:0] dx;
    logic signed [10:0] dy;
    logic signed [21:0] dx_w;
    logic signed [21:0] dy_w;
    logic signed [21:0] dx_sq;
    logic signed [21:0] dy_sq;
    logic        [21:0] dist_sq;
    logic               in_ball;
    logic               in_hoop;
    logic        [11:0] pix_rgb;

    assign dx    = $signed(h) - $signed({1'b0, shadow_x});
    assign dy    = $signed(v) - $signed({1'b0, shadow_y});
    assign dx_w  = {{11{dx[10]}}, dx};
    assign dy_w  = {{11{dy[10]}}, dy};
    assign dx_sq = dx_w * dx_w;
    assign dy_sq = dy_w * dy_w;
    // Both squares are at most 1023^2, so the sum stays below 2^22.
    assign dist_sq = dx_sq + dy_sq;

    assign in_ball = (dist_sq <= RADIUS_SQ);
    assign in_hoop = (h >= HX0) && (h <= HX1) && (v >= HY0) && (v <= HY1);

    // The ball is drawn on top of the hoop; anything outside the visible
    // area is forced to black, which also clips off-screen ball parts.
    always_comb begin
        pix_rgb = BG_RGB;
        if (!active) begin
            pix_rgb = BLANK_RGB;
        end else if (in_ball) begin
            pix_rgb = BALL_RGB;
        end else if (in_hoop) begin
            pix_rgb = HOOP_RGB;
        end
    end

    // Colour and both syncs are registered on the same strobe so they stay
    // aligned, one pixel behind the counters.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            rgb    <= BLANK_RGB;
            VGA_HS <= ~SYNC_LVL;
            VGA_VS <= ~SYNC_LVL;
        end else if (pix_en) begin
            rgb    <= pix_rgb;
            VGA_HS <= hsync;
            VGA_VS <= vsync;
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= vblank_start;
        end
    end

endmodule

// File: tb/tb_vga_sprite_engine.sv
// ---------------------------------------------------------------------------
// tb_vga_sprite_engine
// Self-checking bench for vga_sprite_engine with a shrunken raster so whole
// frames fit in a short run. The reference model derives the raster position
// from the number of clocks since reset (pixel index = clocks / CLK_DIV) and
// colours each pixel from the circle/rectangle rules directly.
// ---------------------------------------------------------------------------
module tb_vga_sprite_engine;

    localparam int HA  = 40;
    localparam int HFP = 4;
    localparam int HSY = 6;
    localparam int HBP = 6;
    localparam int VA  = 24;
    localparam int VFP = 2;
    localparam int VSY = 2;
    localparam int VBP = 2;
    localparam int CD  = 2;
    localparam int R   = 3;
    localparam int HX0 = 30;
    localparam int HX1 = 35;
    localparam int HY0 = 5;
    localparam int HY1 = 7;
    localparam int HT  = HA + HFP + HSY + HBP;      // 56
    localparam int VT  = VA + VFP + VSY + VBP;      // 30
    localparam int FRAME_CLKS = HT * VT * CD;       // 3360
    localparam int FIRST_TICK = VA * HT * CD;       // 2688

    // ---------------- clock / reset ----------------
    logic        clk;
    logic        reset;
    logic [9:0]  ball_x;
    logic [9:0]  ball_y;
    logic [11:0] rgb;
    logic        VGA_HS;
    logic        VGA_VS;
    logic        frame_tick;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vga_sprite_engine #(
        .H_ACTIVE (HA),  .H_FP (HFP), .H_SYNC (HSY), .H_BP (HBP),
        .V_ACTIVE (VA),  .V_FP (VFP), .V_SYNC (VSY), .V_BP (VBP),
        .SYNC_POL (0),   .CLK_DIV (CD), .BALL_R (R),
        .HOOP_X0 (HX0),  .HOOP_X1 (HX1), .HOOP_Y0 (HY0), .HOOP_Y1 (HY1),
        .BG_RGB (12'h000), .BALL_RGB (12'hF80), .HOOP_RGB (12'hF00)
    ) dut (
        .CLK100MHZ  (clk),
        .reset      (reset),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .rgb        (rgb),
        .VGA_HS     (VGA_HS),
        .VGA_VS     (VGA_VS),
        .frame_tick (frame_tick)
    );

    // ---------------- scoreboard state ----------------
    int tests = 0;
    int fails = 0;
    logic [14:0] exp_q[$];       // {frame_tick, VGA_VS, VGA_HS, rgb}

    // model state
    int   n_clk = 0;             // clocks since reset released
    int   sh_x = HA / 2;
    int   sh_y = VA / 2;
    int   cur_h = 0;
    int   cur_v = 0;
    bit   pix_now = 0;
    bit   ft_now = 0;
    logic [11:0] m_rgb = 12'h000;
    logic        m_hs = 1'b1;
    logic        m_vs = 1'b1;

    function automatic logic [11:0] ref_color(input int hh, input int vv,
                                              input int cx, input int cy);
        int ddx, ddy;
        if (hh >= HA || vv >= VA) return 12'h000;
        ddx = hh - cx;
        ddy = vv - cy;
        if (ddx * ddx + ddy * ddy <= R * R) return 12'hF80;
        if (hh >= HX0 && hh <= HX1 && vv >= HY0 && vv <= HY1) return 12'hF00;
        return 12'h000;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance the model by one rising edge using the inputs present at it.
    task automatic model_edge();
        int p;
        pix_now = 0;
        ft_now  = 0;
        if (reset) begin
            n_clk = 0;
            sh_x  = HA / 2;
            sh_y  = VA / 2;
            m_rgb = 12'h000;
            m_hs  = 1'b1;
            m_vs  = 1'b1;
        end else begin
            n_clk++;
            if (n_clk % CD == 0) begin
                p     = n_clk / CD - 1;
                cur_h = p % HT;
                cur_v = (p / HT) % VT;
                m_rgb = ref_color(cur_h, cur_v, sh_x, sh_y);
                m_hs  = (cur_h >= HA + HFP && cur_h < HA + HFP + HSY) ? 1'b0 : 1'b1;
                m_vs  = (cur_v >= VA + VFP && cur_v < VA + VFP + VSY) ? 1'b0 : 1'b1;
                if (cur_h == HT - 1 && cur_v == VA - 1) begin
                    sh_x   = int'(ball_x);
                    sh_y   = int'(ball_y);
                    ft_now = 1;
                end
                pix_now = 1;
            end
        end
        exp_q.push_back({ft_now, m_vs, m_hs, m_rgb});
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        logic [14:0] e;
        @(posedge clk);
        model_edge();
        #1;
        e = exp_q.pop_front();
        chk("scoreboard", int'({frame_tick, VGA_VS, VGA_HS, rgb}), int'(e));
    endtask

    task automatic wait_pixel(input int th, input int tv);
        int k = 0;
        do begin
            step();
            k++;
        end while (!(pix_now && cur_h == th && cur_v == tv) && k < 2 * FRAME_CLKS);
        if (!(pix_now && cur_h == th && cur_v == tv)) begin
            tests++;
            fails++;
            $display("FAIL wait_pixel(%0d,%0d): timeout after %0d clocks", th, tv, k);
        end
    endtask

    task automatic wait_frame();
        int k = 0;
        do begin
            step();
            k++;
        end while (!ft_now && k < 2 * FRAME_CLKS);
        if (!ft_now) begin
            tests++;
            fails++;
            $display("FAIL wait_frame: timeout after %0d clocks", k);
        end
    endtask

    task automatic clocks_to_tick(input string name);
        int k = 0;
        do begin
            step();
            k++;
        end while (frame_tick !== 1'b1 && k < 2 * FRAME_CLKS);
        chk(name, k, FIRST_TICK);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_rgb"}, int'(rgb), 12'h000);
        chk({name, "_hs"},  int'(VGA_HS), 1);
        chk({name, "_vs"},  int'(VGA_VS), 1);
        chk({name, "_ft"},  int'(frame_tick), 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int          bx;
        int          by;
        int          h;
        int          v;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int k;

        // ball (20,15): hoop edges, ball edges, blanking
        vecs.push_back('{20, 15, 30, 5, 12'hF00});
        vecs.push_back('{20, 15, 36, 5, 12'h000});
        vecs.push_back('{20, 15, 32, 6, 12'hF00});
        vecs.push_back('{20, 15, 35, 7, 12'hF00});
        vecs.push_back('{20, 15, 34, 8, 12'h000});
        vecs.push_back('{20, 15, 45, 10, 12'h000});
        vecs.push_back('{20, 15, 20, 15, 12'hF80});
        vecs.push_back('{20, 15, 23, 15, 12'hF80});
        vecs.push_back('{20, 15, 24, 15, 12'h000});
        vecs.push_back('{20, 15, 22, 17, 12'hF80});
        vecs.push_back('{20, 15, 22, 18, 12'h000});
        // ball over the hoop: ball wins, hoop shows around it
        vecs.push_back('{32, 6, 29, 6, 12'hF80});
        vecs.push_back('{32, 6, 35, 7, 12'hF00});
        vecs.push_back('{32, 6, 34, 8, 12'hF80});
        // top-left corner, clipped, no wrap into the blanking columns
        vecs.push_back('{0, 0, 0, 0, 12'hF80});
        vecs.push_back('{0, 0, 3, 0, 12'hF80});
        vecs.push_back('{0, 0, 55, 0, 12'h000});
        vecs.push_back('{0, 0, 3, 1, 12'h000});
        vecs.push_back('{0, 0, 2, 2, 12'hF80});
        vecs.push_back('{0, 0, 0, 3, 12'hF80});
        // centre just past the right edge
        vecs.push_back('{41, 15, 37, 15, 12'h000});
        vecs.push_back('{41, 15, 38, 15, 12'hF80});
        vecs.push_back('{41, 15, 39, 15, 12'hF80});
        vecs.push_back('{41, 15, 41, 15, 12'h000});
        // far off-screen centre: large negative differences
        vecs.push_back('{1023, 1023, 0, 0, 12'h000});
        vecs.push_back('{1023, 1023, 30, 5, 12'hF00});

        // ---- reset and first frame ----
        reset  = 1'b1;
        ball_x = 10'd20;
        ball_y = 10'd15;
        step();
        step();
        step();
        check_reset_outputs("reset");
        reset = 1'b0;
        clocks_to_tick("first_frame_tick_clocks");

        // ---- sync pulse widths ----
        wait_pixel(HA + HFP, 2);
        k = 0;
        while (VGA_HS === 1'b0 && k < 200) begin
            step();
            k++;
        end
        chk("hsync_low_clocks", k, HSY * CD);

        wait_pixel(0, VA + VFP);
        k = 0;
        while (VGA_VS === 1'b0 && k < 1000) begin
            step();
            k++;
        end
        chk("vsync_low_clocks", k, VSY * HT * CD);

        // ---- table-driven pixel checks ----
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].bx != int'(ball_x) || vecs[i].by != int'(ball_y)) begin
                ball_x = 10'(vecs[i].bx);
                ball_y = 10'(vecs[i].by);
                wait_frame();
            end
            wait_pixel(vecs[i].h, vecs[i].v);
            chk($sformatf("vec%0d_(%0d,%0d)", i, vecs[i].h, vecs[i].v),
                int'(rgb), int'(vecs[i].exp));
        end

        // ---- mid-frame position change must not tear ----
        ball_x = 10'd20;
        ball_y = 10'd15;
        wait_frame();
        wait_pixel(0, 5);
        ball_x = 10'd8;
        wait_pixel(8, 15);
        chk("tear_old_frame_x8", int'(rgb), 12'h000);
        wait_pixel(20, 15);
        chk("tear_old_frame_x20", int'(rgb), 12'hF80);
        wait_pixel(8, 15);
        chk("tear_new_frame_x8", int'(rgb), 12'hF80);
        wait_pixel(20, 15);
        chk("tear_new_frame_x20", int'(rgb), 12'h000);

        // ---- random positions changed at random times ----
        for (int i = 0; i < 3 * FRAME_CLKS; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                ball_x = 10'($urandom_range(0, 63));
                ball_y = 10'($urandom_range(0, 40));
            end
            step();
        end

        // ---- reset in the middle of a frame ----
        ball_x = 10'd20;
        ball_y = 10'd15;
        wait_pixel(30, 20);
        reset = 1'b1;
        step();
        step();
        check_reset_outputs("midframe_reset");
        reset = 1'b0;
        clocks_to_tick("restart_frame_tick_clocks");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_sprite_engine.md
VGA_SPRITE_ENGINE -- requirements
Module: vga_sprite_engine

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, meaning visible pixels per line.
REQ-002 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, meaning horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480, meaning visible lines.
REQ-004 SHALL have parameters V_FP/V_SYNC/V_BP, defaults 10/2/33, meaning vertical porch and sync widths in lines.
REQ-005 SHALL have parameter SYNC_POL, default 0, meaning the asserted sync level (0 = active-low).
REQ-006 SHALL have parameter CLK_DIV, default 4, meaning system clocks per pixel (minimum 1).
REQ-007 SHALL have parameter BALL_R, default 8, meaning ball radius in pixels.
REQ-008 SHALL have parameters HOOP_X0/HOOP_X1/HOOP_Y0/HOOP_Y1, defaults 560/600/120/126, meaning the inclusive hoop rectangle.
REQ-009 SHALL have parameters BG_RGB/BALL_RGB/HOOP_RGB, defaults 12'h000/12'hF80/12'hF00.
REQ-010 CLK100MHZ input 1: the single clock; all logic is on its rising edge.
REQ-011 reset input 1: synchronous, active-high reset.
REQ-012 ball_x input 10: ball centre column.
REQ-013 ball_y input 10: ball centre row.
REQ-014 rgb output 12: pixel colour, {R[3:0],G[3:0],B[3:0]}.
REQ-015 VGA_HS output 1: horizontal sync.
REQ-016 VGA_VS output 1: vertical sync.
REQ-017 frame_tick output 1: single-clock pulse at the start of vertical blank.

Function
REQ-018 The divider SHALL count 0..CLK_DIV-1 and wrap, and SHALL produce pix_en for one clock when the count equals CLK_DIV-1.
REQ-019 The h counter SHALL advance only on pix_en and SHALL wrap from H_TOTAL-1 to 0, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
REQ-020 The v counter SHALL increment only on pix_en when h equals H_TOTAL-1, and SHALL wrap from V_TOTAL-1 to 0.
REQ-021 On each pix_en, rgb/VGA_HS/VGA_VS SHALL be registered from the current (h,v), which gives one pixel tick of latency with all three outputs aligned.
REQ-022 VGA_HS SHALL be at SYNC_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, and at ~SYNC_POL otherwise; VGA_VS SHALL follow the same rule on v.
REQ-023 rgb SHALL be 12'h000 whenever h >= H_ACTIVE or v >= V_ACTIVE.
REQ-024 In the active region, rgb SHALL be BALL_RGB if dx^2+dy^2 <= BALL_R^2, else HOOP_RGB if the pixel is inside the hoop rectangle, else BG_RGB.
REQ-025 dx and dy SHALL be signed differences (pixel minus latched centre) computed at 11 bits, with squares and sum at 22 bits, so no overflow occurs at screen edges.
REQ-026 ball_x/ball_y SHALL be sampled into shadow registers only on the pix_en where the v counter transitions to V_ACTIVE (h wraps at line V_ACTIVE-1), so a frame never tears.
REQ-027 frame_tick SHALL pulse in that same clock.
REQ-028 Centres partially or fully off-screen SHALL be legal and SHALL simply clip.
REQ-029 Parts of the ball outside the active area SHALL be suppressed by REQ-023.

Reset
REQ-030 Reset SHALL clear divider, h and v to 0.
REQ-031 Reset SHALL set rgb to 12'h000, VGA_HS/VGA_VS to ~SYNC_POL, and frame_tick to 0.
REQ-032 Reset SHALL set the shadow position to (H_ACTIVE/2, V_ACTIVE/2).
REQ-033 Reset asserted mid-line or mid-frame SHALL take effect on the next edge, and the first pix_en after release SHALL occur CLK_DIV clocks later.

Structure
REQ-034 A shared package vga_pkg SHALL hold the default timing constants, derived H_TOTAL/V_TOTAL, and the colour constants.
REQ-035 The design SHALL contain one sub-module, vga_timing, holding the divider, h/v counters and sync decode, and outputting pix_en, h, v, active and vblank_start.
REQ-036 The ball/hoop compositor and the shadow registers SHALL live in vga_sprite_engine.

Verification
REQ-037 Defaults, reset released: first pix_en 4 clocks later; line period 3200 clocks; frame period 1,680,000 clocks.
REQ-038 VGA_HS low for exactly 384 clocks starting at h=656; VGA_VS low for lines 490-491 only; both high elsewhere.
REQ-039 ball=(320,240): pixel (320,240) = 12'hF80; (328,240) = 12'hF80; (329,240) = 12'h000; (580,122) = 12'hF00; h=700 = 12'h000.
REQ-040 Change ball_x 320->100 at line 100: the rest of that frame is still drawn at x=320; the next frame draws at x=100; frame_tick pulses once per frame, at v=480,h=0.
REQ-041 ball=(0,0): pixel (0,0) = 12'hF80, no wrap artefacts at h=H_TOTAL-1.
REQ-042 Reset asserted at h=300,v=200 for 2 clocks: all outputs at reset values; timing restarts from h=0,v=0.
